spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- SPI transaction controller clocked by the serial clock sclk. It sits directly upstream of the SPI slave and drives its cs, mosi, load, read and data_in inputs.
- Per transaction: preloads a byte into the slave, full-duplex shifts WIDTH bits LSB-first, then pulses read so the slave publishes the byte it received.
- The host side uses a valid/ready request and returns the byte shifted out of the slave on miso.

Parameters:
- WIDTH, 8, transfer length in bits; also the width of the tx, preload and rx buses.
- GAP_CYCLES, 1, minimum idle sclk cycles with cs high between transfers. Range 0..15.

Ports:
- sclk  input  1  serial/system clock. All master logic is on the posedge.
- reset  input  1  synchronous, active-low reset.
- tx_valid  input  1  host request.
- tx_ready  output  1  master can accept a request.
- tx_data  input  WIDTH  byte to shift out on mosi.
- preload_data  input  WIDTH  byte to preload into the slave shift register.
- rx_valid  output  1  one-cycle pulse; rx_data holds the received byte.
- rx_data  output  WIDTH  byte sampled from miso, LSB first.
- busy  output  1  high from acceptance until return to IDLE.
- cs  output  1  slave chip select, active-low.
- mosi  output  1  serial data to the slave.
- miso  input  1  serial data from the slave; the slave updates it on negedge.
- load  output  1  slave preload strobe.
- read  output  1  slave read strobe.
- slv_data_in  output  WIDTH  parallel preload bus to the slave.

Behaviour:
- All outputs are registered on posedge sclk, so they are stable at the slave's negedge.
- Reset (reset=0 at posedge):
  - state=IDLE, cs=1, mosi=0, load=0, read=0, slv_data_in=0.
  - rx_data=0, rx_valid=0, busy=0, tx_ready=1, bit counter=0, gap counter=0.
- States and transitions:
  - IDLE: tx_ready = (gap_cnt==0). If tx_valid && tx_ready, latch tx_data into tx_sh and preload_data into slv_data_in, then go to LOAD.
  - IDLE with gap_cnt>0: decrement gap_cnt; tx_valid is ignored.
  - LOAD (1 cycle): load=1, cs=1. Next state is SHIFT with bit_cnt=0, mosi=tx_sh[0], cs=0.
  - SHIFT (WIDTH cycles): cs=0, load=0, mosi=tx_sh[bit_cnt].
    - Each posedge ending a SHIFT cycle samples miso into rx_sh[bit_cnt] and increments bit_cnt.
    - After bit_cnt reaches WIDTH-1 and is sampled, go to READ.
  - READ (1 cycle): cs=1, read=1, mosi=0, rx_data=rx_sh, rx_valid=1. Then go to IDLE with gap_cnt=GAP_CYCLES.
- Latency: the acceptance edge is cycle 0.
  - load is high in cycle 1.
  - cs is low in cycles 2..WIDTH+1.
  - read and rx_valid are high in cycle WIDTH+2 (cycle 10 for WIDTH=8).
  - The next accept is at the earliest in cycle WIDTH+3+GAP_CYCLES.
- busy = (state != IDLE). tx_ready=0 whenever busy or gap_cnt>0.
- Bit order is LSB first in both directions.
  - After a transfer the slave shift register holds tx_data, and rx_data equals the slave's preloaded byte.
  - The master never issues more than WIDTH shift cycles per cs-low window.
- rx_data holds its value until the next READ. rx_valid is exactly one cycle; there is no back-pressure on rx.
- tx_valid during busy is ignored, not queued. tx_data and preload_data are sampled only at acceptance.
- tx_valid with GAP_CYCLES=0: back-to-back transfers are allowed. cs goes high in the READ cycle and in the new LOAD cycle, and is never low across two transfers.
- Reset mid-transfer: the next posedge forces IDLE, cs=1 and all strobes low. The partial rx_sh is discarded and no rx_valid is issued.
- load and read are never high together. Neither is ever high while cs=0.

Test Plan:
- Reset, then tx_data=8'hA5, preload_data=8'h3C -> load is high in cycle 1; cs is low for exactly 8 cycles; mosi sequence is 1,0,1,0,0,1,0,1; rx_valid pulses in cycle 10 with rx_data=8'h3C; slave data_out=8'hA5 while read=1.
- Back-to-back with GAP_CYCLES=1: 8'hFF/8'h00 then 8'h00/8'hFF held valid -> second accept is exactly 2 cycles after the first READ; the rx results are 8'h00 then 8'hFF; cs has at least 1 high cycle between the windows.
- tx_valid pulsed with 8'h11 during SHIFT of the 8'h5A transfer -> ignored; tx_ready=0 throughout; exactly one rx_valid; slave receives 8'h5A.
- reset asserted in the 4th SHIFT cycle -> next posedge gives cs=1, busy=0, load=read=0; no rx_valid; a following 8'hC3/8'h81 transfer completes with rx_data=8'h81.
- Random 200 transfers against the slave model -> each rx_data equals its preload_data; each slave data_out equals its tx_data; the load/read/cs exclusivity assertions never fire.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// Host request/response and slave-side SPI signals of the SPI transaction controller.
interface spi_master_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] preload_data;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             busy;
  logic             cs;
  logic             mosi;
  logic             miso;
  logic             load;
  logic             read;
  logic [WIDTH-1:0] slv_data_in;

  modport master (
    input  tx_valid, tx_data, preload_data, miso,
    output tx_ready, rx_valid, rx_data, busy, cs, mosi, load, read, slv_data_in
  );

  modport slave (
    output tx_valid, tx_data, preload_data, miso,
    input  tx_ready, rx_valid, rx_data, busy, cs, mosi, load, read, slv_data_in
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI transaction controller: preload the slave, shift WIDTH bits LSB-first, then strobe read.
// Every output is a flop on posedge sclk so the slave sees stable levels at its negedge.
module spi_master_ctrl #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input logic               sclk,
  input logic               reset,
  spi_master_ctrl_if.master bus
);
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LOAD = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, READ} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d, rx_next;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [WIDTH-1:0] slv_q, slv_d;
  logic             cs_q, cs_d, mosi_q, mosi_d;
  logic             load_q, load_d, read_q, read_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q, busy_d, tx_ready_q, tx_ready_d;

  always_ff @(posedge sclk) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      gap_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      slv_q      <= '0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      load_q     <= 1'b0;
      read_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_q      <= gap_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      slv_q      <= slv_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      load_q     <= load_d;
      read_q     <= read_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    gap_d      = gap_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    slv_d      = slv_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    load_d     = 1'b0;
    read_d     = 1'b0;
    rx_valid_d = 1'b0;
    bit_nxt    = bit_cnt_q + 1'b1;
    rx_next    = rx_sh_q;
    rx_next[bit_cnt_q] = bus.miso;

    case (state_q)
      IDLE: begin
        // Requests arriving while the inter-transfer gap runs are dropped, not held.
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 1'b1;
        end else if (bus.tx_valid) begin
          tx_sh_d = bus.tx_data;
          slv_d   = bus.preload_data;
          cs_d    = 1'b1;
          load_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bit_cnt_d = '0;
        mosi_d    = tx_sh_q[0];
        cs_d      = 1'b0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        rx_sh_d = rx_next;
        if (bit_cnt_q == LAST_BIT) begin
          // Last bit goes straight into rx_data so the result is visible in the READ cycle.
          rx_data_d  = rx_next;
          rx_valid_d = 1'b1;
          read_d     = 1'b1;
          cs_d       = 1'b1;
          mosi_d     = 1'b0;
          state_d    = READ;
        end else begin
          bit_cnt_d = bit_nxt;
          mosi_d    = tx_sh_q[bit_nxt];
        end
      end
      READ: begin
        gap_d   = GAP_LOAD;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE);
    tx_ready_d = (state_d == IDLE) && (gap_d == 4'd0);
  end

  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.busy        = busy_q;
  assign bus.cs          = cs_q;
  assign bus.mosi        = mosi_q;
  assign bus.load        = load_q;
  assign bus.read        = read_q;
  assign bus.slv_data_in = slv_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: negedge SPI slave model, timetable reference model, directed and random traffic.
module tb_spi_master_ctrl;
  localparam int W   = 8;
  localparam int GAP = 1;

  logic sclk  = 1'b0;
  logic reset = 1'b0;

  spi_master_ctrl_if #(.WIDTH(W)) bif();

  spi_master_ctrl #(.WIDTH(W), .GAP_CYCLES(GAP)) dut (
    .sclk  (sclk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 sclk = ~sclk;

  // Slave: preload on load, shift LSB-first while selected, publish on read.
  logic [W-1:0] s_sr   = '0;
  logic [W-1:0] s_out  = '0;
  logic         s_miso = 1'b0;
  assign bif.miso = s_miso;

  always @(negedge sclk) begin
    if (bif.load) begin
      s_sr <= bif.slv_data_in;
    end else if (!bif.cs) begin
      s_miso <= s_sr[0];
      s_sr   <= {bif.mosi, s_sr[W-1:1]};
    end
    if (bif.read) s_out <= s_sr;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer accepted at edge A occupies cycles A+1..A+W+2, next accept at A+W+3+GAP.
  int           ecnt       = 0;
  bit           model_on   = 1'b0;
  bit           have_xfer  = 1'b0;
  int           acc_e      = 0;
  int           next_free  = 0;
  int           model_done = 0;
  int           csl_run    = 0;
  logic [W-1:0] acc_tx     = '0;
  logic [W-1:0] acc_pre    = '0;
  logic [W-1:0] exp_rx     = '0;

  always @(posedge sclk) begin
    int e, r, e_load, e_cs, e_mosi, e_rd, e_busy, e_rdy;
    e = ecnt;
    ecnt++;
    if (model_on && have_xfer && (e - acc_e) == W + 2)
      chk("slave_data_out", 32'(s_out), 32'(acc_tx));
    if (!reset) begin
      model_on  = 1'b1;
      have_xfer = 1'b0;
      next_free = e + 1;
      exp_rx    = '0;
    end else if (model_on && bif.tx_valid && e >= next_free) begin
      have_xfer = 1'b1;
      acc_e     = e;
      acc_tx    = bif.tx_data;
      acc_pre   = bif.preload_data;
      next_free = e + W + 3 + GAP;
    end
    #1;
    if (model_on) begin
      r      = have_xfer ? (e + 1 - acc_e) : -1;
      e_load = (r == 1) ? 1 : 0;
      e_cs   = (r >= 2 && r <= W + 1) ? 0 : 1;
      e_mosi = (r >= 2 && r <= W + 1) ? 32'(acc_tx[r-2]) : 0;
      e_rd   = (r == W + 2) ? 1 : 0;
      e_busy = (r >= 1 && r <= W + 2) ? 1 : 0;
      e_rdy  = (e + 1 >= next_free) ? 1 : 0;
      if (e_rd == 1) begin
        exp_rx = acc_pre;
        model_done++;
      end
      chk("cs",       32'(bif.cs),       e_cs);
      chk("load",     32'(bif.load),     e_load);
      chk("read",     32'(bif.read),     e_rd);
      chk("rx_valid", 32'(bif.rx_valid), e_rd);
      chk("busy",     32'(bif.busy),     e_busy);
      chk("tx_ready", 32'(bif.tx_ready), e_rdy);
      chk("mosi",     32'(bif.mosi),     e_mosi);
      chk("rx_data",  32'(bif.rx_data),  32'(exp_rx));
      chk("load_read_excl", 32'(bif.load & bif.read), 0);
      chk("strobe_cs_excl", 32'((bif.load | bif.read) & ~bif.cs), 0);
      if (!bif.cs) csl_run++;
      else csl_run = 0;
      chk("cs_window_len", 32'(csl_run <= W), 1);
    end
  end

  logic         cap_load[64], cap_cs[64], cap_rv[64], cap_rd[64];
  logic         cap_busy[64], cap_rdy[64], cap_mosi[64];
  logic [W-1:0] cap_rx[64];

  // Called 1 time unit after an edge; sample k is cycle k+1 relative to the preceding accept.
  task automatic capture(input int n, input int act_k, input int kind);
    for (int k = 0; k < n; k++) begin
      cap_load[k] = bif.load;   cap_cs[k]  = bif.cs;       cap_rv[k]   = bif.rx_valid;
      cap_rd[k]   = bif.read;   cap_busy[k] = bif.busy;    cap_rdy[k]  = bif.tx_ready;
      cap_mosi[k] = bif.mosi;   cap_rx[k]  = bif.rx_data;
      if (k == act_k) begin
        case (kind)
          1: bif.tx_valid = 1'b0;
          2: begin bif.tx_valid = 1'b1; bif.tx_data = 8'h11; bif.preload_data = 8'hEE; end
          3: reset = 1'b0;
          default: ;
        endcase
      end
      if (k == act_k + 1) begin
        if (kind == 2) bif.tx_valid = 1'b0;
        if (kind == 3) reset = 1'b1;
      end
      @(posedge sclk); #1;
    end
  endtask

  task automatic start_xfer(input logic [W-1:0] td, input logic [W-1:0] pd, input bit drop);
    bif.tx_valid = 1'b1; bif.tx_data = td; bif.preload_data = pd;
    @(posedge sclk); #1;
    if (drop) bif.tx_valid = 1'b0;
  endtask

  initial begin
    int c_lo, rvk, rvn, l1, l2, hi_between, rdy_hi, target, budget;
    logic [W-1:0] mv, rx1, rx2;
    bit in1, out1, in2;

    bif.tx_valid = 1'b0; bif.tx_data = '0; bif.preload_data = '0;
    repeat (3) @(posedge sclk);
    #1 reset = 1'b1;
    chk("reset_cs", 32'(bif.cs), 1);
    chk("reset_tx_ready", 32'(bif.tx_ready), 1);
    chk("reset_rx_data", 32'(bif.rx_data), 0);
    @(posedge sclk); #1;

    // A5 out, 3C preloaded
    start_xfer(8'hA5, 8'h3C, 1'b1);
    capture(14, -5, 0);
    c_lo = 0; mv = '0; rvk = -1; rvn = 0; rx1 = '0;
    for (int k = 0; k < 14; k++) begin
      if (!cap_cs[k]) begin
        if (c_lo < W) mv[c_lo] = cap_mosi[k];
        c_lo++;
      end
      if (cap_rv[k]) begin rvk = k; rvn++; rx1 = cap_rx[k]; end
    end
    chk("t1_load_cycle1", 32'(cap_load[0]), 1);
    chk("t1_cs_low_cycles", c_lo, 8);
    chk("t1_mosi_seq", 32'(mv), 'hA5);
    chk("t1_rx_valid_cycle", rvk + 1, 10);
    chk("t1_rx_data", 32'(rx1), 'h3C);
    chk("t1_slave_out", 32'(s_out), 'hA5);

    // Back-to-back: FF/00 then 00/FF with valid held
    start_xfer(8'hFF, 8'h00, 1'b0);
    bif.tx_data = 8'h00; bif.preload_data = 8'hFF;
    capture(24, 12, 1);
    l1 = -1; l2 = -1; rvn = 0; rx1 = '0; rx2 = '0;
    hi_between = 0; in1 = 0; out1 = 0; in2 = 0;
    for (int k = 0; k < 24; k++) begin
      if (cap_load[k]) begin if (l1 < 0) l1 = k; else l2 = k; end
      if (cap_rv[k]) begin if (rvn == 0) rx1 = cap_rx[k]; else rx2 = cap_rx[k]; rvn++; end
      if (!cap_cs[k]) begin
        if (out1) in2 = 1; else in1 = 1;
      end else if (in1 && !in2) begin
        out1 = 1; hi_between++;
      end
    end
    chk("t2_accept_spacing", l2 - l1, 12);
    chk("t2_rx_count", rvn, 2);
    chk("t2_rx_first", 32'(rx1), 'h00);
    chk("t2_rx_second", 32'(rx2), 'hFF);
    chk("t2_cs_high_between", hi_between, 4);

    // Request pulsed mid-SHIFT must be ignored
    start_xfer(8'h5A, 8'h96, 1'b1);
    capture(16, 4, 2);
    rdy_hi = 0; rvn = 0; rx1 = '0;
    for (int k = 0; k < 16; k++) begin
      if (k < 11 && cap_rdy[k]) rdy_hi++;
      if (cap_rv[k]) begin rvn++; rx1 = cap_rx[k]; end
    end
    chk("t3_tx_ready_low", rdy_hi, 0);
    chk("t3_rx_count", rvn, 1);
    chk("t3_rx_data", 32'(rx1), 'h96);
    chk("t3_slave_out", 32'(s_out), 'h5A);

    // Reset in the 4th SHIFT cycle, then a clean C3/81 transfer
    start_xfer(8'h77, 8'h22, 1'b1);
    capture(10, 4, 3);
    rvn = 0;
    for (int k = 0; k < 10; k++) if (cap_rv[k]) rvn++;
    chk("t4_cs_after_reset", 32'(cap_cs[5]), 1);
    chk("t4_busy_after_reset", 32'(cap_busy[5]), 0);
    chk("t4_strobes_after_reset", 32'(cap_load[5] | cap_rd[5]), 0);
    chk("t4_ready_after_reset", 32'(cap_rdy[5]), 1);
    chk("t4_no_rx_valid", rvn, 0);
    start_xfer(8'hC3, 8'h81, 1'b1);
    capture(14, -5, 0);
    rvn = 0; rx1 = '0;
    for (int k = 0; k < 14; k++) if (cap_rv[k]) begin rvn++; rx1 = cap_rx[k]; end
    chk("t4_rx_count", rvn, 1);
    chk("t4_rx_data", 32'(rx1), 'h81);
    chk("t4_slave_out", 32'(s_out), 'hC3);

    // Random traffic with occasional resets
    target = model_done + 200;
    budget = 0;
    while (model_done < target && budget < 20000) begin
      @(negedge sclk);
      budget++;
      reset            = ($urandom_range(0, 499) != 0);
      bif.tx_valid     = ($urandom_range(0, 3) != 0);
      bif.tx_data      = W'($urandom);
      bif.preload_data = W'($urandom);
    end
    @(negedge sclk);
    reset = 1'b1;
    bif.tx_valid = 1'b0;
    n_tests++;
    if (model_done < target) begin
      n_fail++;
      $display("FAIL random_budget: completed %0d, required %0d", model_done, target);
    end
    repeat (20) @(posedge sclk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
